// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the AES128 SoC bus initiator and slaves.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite initiator: turns a valid/ready command stream into pipelined
// NONSEQ transfers and returns one response per command.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int unsigned     ADDR_WIDTH   = 32,
    parameter int unsigned     DATA_WIDTH   = 32,
    parameter int unsigned     HBURST_WIDTH = 3,
    parameter int unsigned     HPROT_WIDTH  = 4,
    parameter logic [HPROT_WIDTH-1:0] HPROT_VAL = 4'b0011
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [2:0]              cmd_size,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    output logic                    rsp_valid,
    output logic                    rsp_write,
    output logic                    rsp_err,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   HADDR,
    output logic                    HWRITE,
    output logic [2:0]              HSIZE,
    output logic [HBURST_WIDTH-1:0] HBURST,
    output logic [HPROT_WIDTH-1:0]  HPROT,
    output logic [1:0]              HTRANS,
    output logic                    HMASTLOCK,
    output logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic                    HREADY,
    input  logic                    HRESP,
    input  logic [DATA_WIDTH-1:0]   HRDATA
);

    logic [1:0]            htrans_q, htrans_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic                  hwrite_q, hwrite_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [DATA_WIDTH-1:0] ap_wdata_q, ap_wdata_d;
    logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
    logic                  dp_valid_q, dp_valid_d;
    logic                  dp_write_q, dp_write_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic ap_valid;
    logic accept;

    assign ap_valid  = (htrans_q == HTRANS_NONSEQ);
    // A driven NONSEQ must stay put until the bus samples it with HREADY high.
    assign cmd_ready = HREADY | ~ap_valid;
    assign accept    = cmd_valid & cmd_ready;

    always_comb begin
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        ap_wdata_d  = ap_wdata_q;
        hwdata_d    = hwdata_q;
        dp_valid_d  = dp_valid_q;
        dp_write_d  = dp_write_q;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;

        if (accept) begin
            htrans_d   = HTRANS_NONSEQ;
            haddr_d    = cmd_addr;
            hwrite_d   = cmd_write;
            hsize_d    = cmd_size;
            ap_wdata_d = cmd_wdata;
        end else if (HREADY) begin
            htrans_d = HTRANS_IDLE;
        end

        if (HREADY) begin
            dp_valid_d = ap_valid;
            dp_write_d = hwrite_q;
            hwdata_d   = ap_wdata_q;
        end

        rsp_valid_d = HREADY & dp_valid_q;
        if (rsp_valid_d) begin
            rsp_write_d = dp_write_q;
            rsp_err_d   = (HRESP == HRESP_ERROR);
            rsp_rdata_d = (dp_write_q || HRESP == HRESP_ERROR) ? '0 : HRDATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= HSIZE_WORD;
            ap_wdata_q  <= '0;
            hwdata_q    <= '0;
            dp_valid_q  <= 1'b0;
            dp_write_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            ap_wdata_q  <= ap_wdata_d;
            hwdata_q    <= hwdata_d;
            dp_valid_q  <= dp_valid_d;
            dp_write_q  <= dp_write_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign HTRANS    = htrans_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = HBURST_WIDTH'(HBURST_SINGLE);
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = ap_valid | dp_valid_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: memory slave with wait/error injection, scoreboard of responses.
module tb_ahb_lite_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_write, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;

    ahb_lite_master dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- slave model: 64-word memory, wait/error injection -------------
    logic [31:0] mem [0:63];
    logic [31:0] cfg_wait_addr = 32'hFFFF_FFF0;
    int          cfg_wait_n    = 0;
    logic [31:0] cfg_err_addr  = 32'hFFFF_FFF0;

    logic        sl_act, sl_wr, sl_err, sl_errph;
    logic [31:0] sl_addr;
    int          sl_waits;

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = mem[sl_addr[7:2]];
        if (sl_act) begin
            if (sl_err) begin
                HRESP  = 1'b1;
                HREADY = sl_errph;
            end else if (sl_waits > 0) begin
                HREADY = 1'b0;
            end
        end
    end

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sl_act   <= 1'b0;
            sl_wr    <= 1'b0;
            sl_err   <= 1'b0;
            sl_errph <= 1'b0;
            sl_addr  <= 32'h0;
            sl_waits <= 0;
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
        end else if (HREADY) begin
            if (sl_act && sl_wr && !sl_err) mem[sl_addr[7:2]] <= HWDATA;
            sl_act   <= (HTRANS == 2'b10);
            sl_addr  <= HADDR;
            sl_wr    <= HWRITE;
            sl_waits <= (HADDR == cfg_wait_addr) ? cfg_wait_n : 0;
            sl_err   <= (HADDR == cfg_err_addr);
            sl_errph <= 1'b0;
        end else begin
            if (sl_err) sl_errph <= 1'b1;
            else if (sl_waits > 0) sl_waits <= sl_waits - 1;
        end
    end

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    int   rsp_log[$];
    exp_t mon_e;

    always @(negedge HCLK) begin
        if (rsp_valid === 1'b1) begin
            rsp_log.push_back(cyc);
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 want no response (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_write", 32'(rsp_write), 32'(mon_e.wr));
                check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                check("rsp_rdata", rsp_rdata, mon_e.rdata);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata, output int acc);
        exp_t e;
        logic got;
        int   n;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_size  = 3'b010;
        cmd_wdata = wdata;
        e.wr = wr;
        e.err = exp_err;
        e.rdata = exp_rdata;
        sb_q.push_back(e);
        n = 0;
        do begin
            got = cmd_ready;
            @(posedge HCLK);
            #1;
            n++;
        end while (!got && n < 20);
        acc = cyc;
        if (!got) begin
            n_checks++;
            $display("FAIL accept_timeout: got no acceptance want acceptance of %h", addr);
        end
        check("htrans_nonseq", 32'(HTRANS), 32'h2);
        check("haddr", HADDR, addr);
        check("hwrite", 32'(HWRITE), 32'(wr));
        check("busy_active", 32'(busy), 32'h1);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) begin
            @(posedge HCLK);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        cmd_valid = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin
            @(posedge HCLK);
            #1;
            n++;
        end
        check("drain_pending", 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, a[4];
        HRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_size  = 3'b010;
        cmd_wdata = 32'h0;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwrite", 32'(HWRITE), 32'h0);
        check("rst_hsize", 32'(HSIZE), 32'h2);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_write", 32'(rsp_write), 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_hprot", 32'(HPROT), 32'h3);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        HRESETn = 1'b1;
        idle(2);

        // Idle bus: constant controls and no activity.
        for (int i = 0; i < 4; i++) begin
            check("idle_bus", {26'h0, HTRANS, HBURST, HMASTLOCK}, 32'h0);
            check("idle_busy", 32'(busy), 32'h0);
            idle(1);
        end

        // Write then read back at 0x10; second NONSEQ one cycle after the first.
        issue(1'b1, 32'h10, 32'hCAFE_BABE, 1'b0, 32'h0, a0);
        issue(1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFE_BABE, a1);
        check("wr_rd_back_to_back", 32'(a1 - a0), 32'h1);
        drain();
        idle(1);

        // Four streamed reads: one acceptance and one response per cycle, in order.
        rsp_log.delete();
        for (int i = 0; i < 4; i++)
            issue(1'b0, 32'(4 * i), 32'h0, 1'b0, 32'hA5A5_0000 | 32'(i), a[i]);
        drain();
        for (int i = 0; i < 4; i++) begin
            check("stream_accept_cyc", 32'(a[i] - a[0]), 32'(i));
            check("stream_rsp_cyc", 32'(rsp_log[i] - a[0]), 32'(i + 2));
        end
        idle(1);

        // Two wait states on read 0x20 with write 0x24 queued in the address phase.
        cfg_wait_addr = 32'h20;
        cfg_wait_n    = 2;
        rsp_log.delete();
        issue(1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5_0008, a0);
        issue(1'b1, 32'h24, 32'h5555_AAAA, 1'b0, 32'h0, a1);
        cmd_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("wait_htrans_held", 32'(HTRANS), 32'h2);
            check("wait_haddr_held", HADDR, 32'h24);
            check("wait_cmd_ready", 32'(cmd_ready), 32'h0);
            idle(1);
        end
        check("wait_cmd_ready_release", 32'(cmd_ready), 32'h1);
        drain();
        check("wait_rd_rsp_cyc", 32'(rsp_log[0] - a0), 32'h4);
        check("wait_wr_rsp_cyc", 32'(rsp_log[1] - a0), 32'h5);
        idle(1);

        // Two-cycle ERROR on read 0x40; queued write 0x44 still completes cleanly.
        cfg_err_addr = 32'h40;
        issue(1'b0, 32'h40, 32'h0, 1'b1, 32'h0, a0);
        issue(1'b1, 32'h44, 32'h1234_5678, 1'b0, 32'h0, a1);
        drain();
        issue(1'b0, 32'h44, 32'h0, 1'b0, 32'h1234_5678, a0);
        issue(1'b0, 32'h24, 32'h0, 1'b0, 32'h5555_AAAA, a1);
        drain();
        idle(1);

        // Reset during a wait-stated data phase: everything clears, no response follows.
        cfg_wait_n = 3;
        issue(1'b0, 32'h20, 32'h0, 1'b0, 32'hA5A5_0008, a0);
        idle(1);
        check("pre_rst_hready", 32'(HREADY), 32'h0);
        #3;
        HRESETn = 1'b0;
        void'(sb_q.pop_back());
        #1;
        check("async_rst_htrans", 32'(HTRANS), 32'h0);
        check("async_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        idle(1);
        HRESETn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("post_rst_htrans", 32'(HTRANS), 32'h0);
            check("post_rst_busy", 32'(busy), 32'h0);
            idle(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
